// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, conditions, shift controls,
// NZCV flag positions, FSM states and the condition evaluator.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_AND  = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_MOVI = 4'b0110,
        OP_MOV  = 4'b0111,
        OP_CMP  = 4'b1011,
        OP_NOP  = 4'b1111
    } opcode_e;

    typedef enum logic [3:0] {
        COND_AL = 4'b0000,
        COND_EQ = 4'b0001,
        COND_GT = 4'b0010,
        COND_LT = 4'b0011,
        COND_GE = 4'b0100,
        COND_LE = 4'b0101,
        COND_HI = 4'b0110,
        COND_LO = 4'b0111,
        COND_HS = 4'b1000
    } cond_e;

    typedef enum logic [2:0] {
        SH_NONE = 3'b000,
        SH_LSR  = 3'b001,
        SH_LSL  = 3'b010,
        SH_ROR  = 3'b011
    } sh_ctl_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Unlisted condition codes behave as AL.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        case (cond)
            COND_EQ: cond_eval = z;
            COND_GT: cond_eval = !z && (n == v);
            COND_LT: cond_eval = (n != v);
            COND_GE: cond_eval = (n == v);
            COND_LE: cond_eval = z || (n != v);
            COND_HI: cond_eval = c && !z;
            COND_LO: cond_eval = !c;
            COND_HS: cond_eval = c;
            default: cond_eval = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles,
// keeps the low WIDTH bits of the product. done pulses for one cycle.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] count;
    logic             busy;

    // result doubles as the accumulator and holds the product once done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (start) begin
            result <= '0;
            mcand  <= a;
            mplier <= b;
            count  <= CNT_W'(WIDTH);
            busy   <= 1'b1;
            done   <= 1'b0;
        end else if (busy) begin
            if (mplier[0])
                result <= result + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - 1'b1;
            if (count == CNT_W'(1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered, valid/ready handshaked ALU with a persistent NZCV register,
// conditional execution and an iterative multiplier; one operation in flight.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_opcode,
    input  logic [3:0]       in_cond,
    input  logic             in_s,
    input  logic [2:0]       in_sh_ctl,
    input  logic [SH_W-1:0]  in_sh_amt,
    input  logic [IMM_W-1:0] in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cond_met,
    output logic [3:0]       flags
);

    import alu_pkg::*;

    state_e           state;
    logic             accept, cond_met, mul_start, mul_done, mul_s;
    logic             legal, op_wr, v_add, v_sub, nxt_met;
    logic [WIDTH-1:0] b_sh, b_sub, logic_res, op_result, nxt_result, mul_result;
    logic [WIDTH:0]   sum, diff;
    logic [3:0]       op_flags, nxt_flags;

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign cond_met  = cond_eval(in_cond, flags);
    assign mul_start = accept && (in_opcode == OP_MUL) && cond_met;

    always_comb begin
        case (in_sh_ctl)
            SH_LSR:  b_sh = in_b >> in_sh_amt;
            SH_LSL:  b_sh = in_b << in_sh_amt;
            SH_ROR:  b_sh = (in_b >> in_sh_amt) | (in_b << (WIDTH - int'(in_sh_amt)));
            default: b_sh = in_b;
        endcase
    end

    // CMP compares against the raw operand, never the shifted one.
    assign b_sub = (in_opcode == OP_CMP) ? in_b : b_sh;
    assign sum   = {1'b0, in_a} + {1'b0, b_sh};
    assign diff  = {1'b0, in_a} - {1'b0, b_sub};
    assign v_add = (in_a[WIDTH-1] == b_sh[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
    assign v_sub = (in_a[WIDTH-1] != b_sub[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);

    always_comb begin
        case (in_opcode)
            OP_OR:   logic_res = in_a | b_sh;
            OP_AND:  logic_res = in_a & b_sh;
            default: logic_res = in_a ^ b_sh;
        endcase
    end

    always_comb begin
        op_result = '0;
        op_flags  = flags;
        op_wr     = 1'b0;
        legal     = 1'b1;
        case (in_opcode)
            OP_ADD: begin
                op_result = sum[WIDTH-1:0];
                op_flags  = {sum[WIDTH-1], ~|sum[WIDTH-1:0], sum[WIDTH], v_add};
                op_wr     = in_s;
            end
            OP_SUB, OP_CMP: begin
                op_result = (in_opcode == OP_CMP) ? '0 : diff[WIDTH-1:0];
                op_flags  = {diff[WIDTH-1], ~|diff[WIDTH-1:0], ~diff[WIDTH], v_sub};
                op_wr     = in_s || (in_opcode == OP_CMP);
            end
            OP_OR, OP_AND, OP_XOR: begin
                op_result = logic_res;
                op_flags  = {logic_res[WIDTH-1], ~|logic_res, flags[FLAG_C], flags[FLAG_V]};
                op_wr     = in_s;
            end
            OP_MUL:  op_result = '0;
            OP_MOVI: op_result = WIDTH'(in_imm);
            OP_MOV:  op_result = in_a;
            default: legal = 1'b0;
        endcase

        nxt_result = '0;
        nxt_met    = 1'b0;
        nxt_flags  = flags;
        if (!legal) begin
            nxt_result = out_result;
            nxt_met    = 1'b1;
        end else if (cond_met) begin
            nxt_result = op_result;
            nxt_met    = 1'b1;
            if (op_wr)
                nxt_flags = op_flags;
        end
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start),
        .a      (in_a),
        .b      (b_sh),
        .done   (mul_done),
        .result (mul_result)
    );

    // An accept in DONE already implies out_ready, so IDLE and DONE share it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_cond_met <= 1'b0;
            flags        <= '0;
            mul_s        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (mul_start) begin
                        state     <= ST_BUSY;
                        out_valid <= 1'b0;
                        mul_s     <= in_s;
                    end else if (accept) begin
                        state        <= ST_DONE;
                        out_valid    <= 1'b1;
                        out_result   <= nxt_result;
                        out_cond_met <= nxt_met;
                        flags        <= nxt_flags;
                    end else if ((state == ST_DONE) && out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (mul_done) begin
                        state        <= ST_DONE;
                        out_valid    <= 1'b1;
                        out_result   <= mul_result;
                        out_cond_met <= 1'b1;
                        if (mul_s)
                            flags <= {mul_result[WIDTH-1], ~|mul_result,
                                      flags[FLAG_C], flags[FLAG_V]};
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed vectors covering flags, conditions,
// shifts, the iterative multiplier, back-pressure and asynchronous reset.
module tb_alu_seq;

    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_s, out_valid, out_ready, out_cond_met;
    logic [31:0] in_a, in_b, out_result;
    logic [3:0]  in_opcode, in_cond, flags;
    logic [2:0]  in_sh_ctl;
    logic [4:0]  in_sh_amt;
    logic [15:0] in_imm;

    int nChecks = 0;
    int nFails  = 0;
    int waited;
    int lat;
    logic sawReady;

    alu_seq #(.WIDTH(32), .IMM_W(16), .SH_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_opcode    (in_opcode),
        .in_cond      (in_cond),
        .in_s         (in_s),
        .in_sh_ctl    (in_sh_ctl),
        .in_sh_amt    (in_sh_amt),
        .in_imm       (in_imm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_cond_met (out_cond_met),
        .flags        (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic checkResult(input string tag, input logic [31:0] res,
                               input logic met, input logic [3:0] fl);
        checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        checkOutput({tag, "_result"}, out_result, res);
        checkOutput({tag, "_met"}, {31'b0, out_cond_met}, {31'b0, met});
        checkOutput({tag, "_flags"}, {28'b0, flags}, {28'b0, fl});
    endtask

    // Called on a negedge; returns on the negedge after the accepting posedge.
    task automatic applyStimulus(input logic [3:0] op, input logic [3:0] cond, input logic s,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] shc, input logic [4:0] sha,
                                 input logic [15:0] imm, output int waitCycles);
        in_opcode = op;
        in_cond   = cond;
        in_s      = s;
        in_a      = a;
        in_b      = b;
        in_sh_ctl = shc;
        in_sh_amt = sha;
        in_imm    = imm;
        in_valid  = 1'b1;
        waitCycles = 0;
        while (!in_ready && waitCycles < 100) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready)
            checkOutput("accept_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_a = '0; in_b = '0; in_opcode = OP_NOP; in_cond = COND_AL;
        in_s = 1'b0; in_sh_ctl = SH_NONE; in_sh_amt = '0; in_imm = '0;
        #1;
        checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_result", out_result, 32'd0);
        checkOutput("rst_met", {31'b0, out_cond_met}, 32'd0);
        checkOutput("rst_flags", {28'b0, flags}, 32'd0);
        checkOutput("rst_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(OP_ADD, COND_AL, 1'b1, 32'h7FFF_FFFF, 32'd1, SH_NONE, 5'd0, 16'h0, waited);
        checkResult("add_ovf", 32'h8000_0000, 1'b1, 4'b1001);

        applyStimulus(OP_CMP, COND_AL, 1'b0, 32'd5, 32'd5, SH_NONE, 5'd0, 16'h0, waited);
        checkResult("cmp_eq", 32'd0, 1'b1, 4'b0110);

        applyStimulus(OP_SUB, COND_EQ, 1'b0, 32'd9, 32'd4, SH_LSL, 5'd1, 16'h0, waited);
        checkResult("sub_lsl_eq", 32'd1, 1'b1, 4'b0110);

        applyStimulus(OP_CMP, COND_AL, 1'b0, 32'd3, 32'd5, SH_NONE, 5'd0, 16'h0, waited);
        checkResult("cmp_lt", 32'd0, 1'b1, 4'b1000);

        applyStimulus(OP_ADD, COND_GT, 1'b1, 32'd1, 32'd1, SH_NONE, 5'd0, 16'h0, waited);
        checkResult("gt_skip", 32'd0, 1'b0, 4'b1000);

        applyStimulus(OP_CMP, COND_AL, 1'b0, 32'hFFFF_FFFF, 32'd1, SH_NONE, 5'd0, 16'h0, waited);
        checkResult("cmp_uns", 32'd0, 1'b1, 4'b1010);

        applyStimulus(OP_MOV, COND_HI, 1'b0, 32'h55, 32'd0, SH_NONE, 5'd0, 16'h0, waited);
        checkResult("hi_met", 32'h55, 1'b1, 4'b1010);
        applyStimulus(OP_MOV, COND_LO, 1'b0, 32'h66, 32'd0, SH_NONE, 5'd0, 16'h0, waited);
        checkResult("lo_skip", 32'd0, 1'b0, 4'b1010);
        applyStimulus(OP_MOV, COND_GT, 1'b0, 32'h77, 32'd0, SH_NONE, 5'd0, 16'h0, waited);
        checkResult("gt_uns_skip", 32'd0, 1'b0, 4'b1010);

        applyStimulus(OP_ADD, COND_AL, 1'b0, 32'd0, 32'h8000_0001, SH_ROR, 5'd1, 16'h0, waited);
        checkResult("ror", 32'hC000_0000, 1'b1, 4'b1010);
        applyStimulus(OP_ADD, COND_AL, 1'b0, 32'd0, 32'h80, SH_LSR, 5'd4, 16'h0, waited);
        checkResult("lsr", 32'd8, 1'b1, 4'b1010);

        applyStimulus(OP_XOR, COND_AL, 1'b1, 32'hF0F0, 32'hF0F0, SH_NONE, 5'd0, 16'h0, waited);
        checkResult("xor_zero", 32'd0, 1'b1, 4'b0110);

        // Multiply: -3 * 7, ready must stay low until the product appears.
        applyStimulus(OP_MUL, COND_AL, 1'b1, 32'hFFFF_FFFD, 32'd7, SH_NONE, 5'd0, 16'h0, waited);
        lat = 0;
        sawReady = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready)
                sawReady = 1'b1;
            @(negedge clk);
            lat++;
        end
        checkOutput("mul_latency", lat, 32'd33);
        checkOutput("mul_ready_low", {31'b0, sawReady}, 32'd0);
        checkResult("mul", 32'hFFFF_FFEB, 1'b1, 4'b1010);

        // Back-to-back with out_ready held high.
        applyStimulus(OP_ADD, COND_AL, 1'b0, 32'd2, 32'd3, SH_NONE, 5'd0, 16'h0, waited);
        checkResult("b2b_add", 32'd5, 1'b1, 4'b1010);
        applyStimulus(OP_MOVI, COND_AL, 1'b0, 32'd0, 32'd0, SH_NONE, 5'd0, 16'hBEEF, waited);
        checkOutput("b2b_wait", waited, 32'd0);
        checkResult("b2b_movi", 32'h0000_BEEF, 1'b1, 4'b1010);

        // Back-pressure: result must hold and no new op may be taken.
        out_ready = 1'b0;
        in_opcode = OP_MOV; in_cond = COND_AL; in_s = 1'b0; in_a = 32'h77;
        in_sh_ctl = SH_NONE; in_sh_amt = '0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("hold_ready", {31'b0, in_ready}, 32'd0);
            checkResult("hold", 32'h0000_BEEF, 1'b1, 4'b1010);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkResult("after_hold", 32'h77, 1'b1, 4'b1010);

        applyStimulus(OP_NOP, COND_AL, 1'b1, 32'h1, 32'h2, SH_NONE, 5'd0, 16'h0, waited);
        checkResult("nop", 32'h77, 1'b1, 4'b1010);

        // Asynchronous reset in the middle of a multiply.
        applyStimulus(OP_MUL, COND_AL, 1'b1, 32'd6, 32'd7, SH_NONE, 5'd0, 16'h0, waited);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("arst_result", out_result, 32'd0);
        checkOutput("arst_flags", {28'b0, flags}, 32'd0);
        checkOutput("arst_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(OP_MOV, COND_AL, 1'b0, 32'h1234, 32'd0, SH_NONE, 5'd0, 16'h0, waited);
        checkResult("post_rst_mov", 32'h1234, 1'b1, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
